// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared constants and FSM/condition types for the sequential divider
package seq_divider_pkg;
  localparam int DW_DEF = 8;
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction
  localparam int CNT_W = cnt_w(DW_DEF);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [1:0] {C_NORM, C_DBZ, C_OVF} cond_t;
endpackage

// File: rtl/seq_divider_step.sv
// div_step: one restoring step on the shifted partial remainder, yielding the next remainder and quotient bit
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   pr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] npr,
  output logic          qb
);
  logic [DW-1:0] diff;
  // keep the trial difference only when the shifted remainder covers the divisor
  always_comb begin
    qb   = pr >= {1'b0, d};
    diff = pr[DW-1:0] - d;
    npr  = qb ? diff : pr[DW-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring 2*DW/DW divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_EN selects two's complement operands
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   q,
  output logic [DW-1:0]   r,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic            ovf
);
  localparam int CW = cnt_w(DW);
  state_t          state;
  cond_t           cond;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rem, quo, dvs, a_lo;
  logic [2*DW-1:0] a_mag;
  logic [DW-1:0]   b_mag;
  logic [DW-1:0]   nrem;
  logic            qb;
  logic [DW-1:0]   q_fin, r_fin;
  logic            ovf_fin;
  logic            early;

  div_step #(.DW(DW)) u_step (
    .pr  ({rem, quo[DW-1]}),
    .d   (dvs),
    .npr (nrem),
    .qb  (qb)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag   = a[2*DW-1] ? -a : a;
  assign b_mag   = b[DW-1] ? -b : b;
  assign q_fin   = neg_q ? -quo : quo;
  assign r_fin   = neg_r ? -rem : rem;
  assign ovf_fin = neg_q ? (quo > {1'b1, {(DW-1){1'b0}}}) : quo[DW-1];
  // remember the operand signs so FIX can restore the signs of quotient and remainder
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= a[2*DW-1] ^ b[DW-1];
      neg_r <= a[2*DW-1];
    end
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign q_fin   = quo;
  assign r_fin   = rem;
  assign ovf_fin = 1'b0;
`endif

  // a zero divisor or an upper half not below the divisor cannot yield a DW-bit quotient
  assign early = (b == '0) || (a_mag[2*DW-1:DW] >= b_mag);

  // control FSM: latch operands, iterate DW restoring steps, then publish results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cond  <= C_NORM;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_lo  <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem   <= a_mag[2*DW-1:DW];
          quo   <= a_mag[DW-1:0];
          dvs   <= b_mag;
          a_lo  <= a[DW-1:0];
          cnt   <= '0;
          busy  <= 1'b1;
          cond  <= (b == '0) ? C_DBZ : early ? C_OVF : C_NORM;
          state <= early ? FIX : CALC;
        end
        CALC: begin
          rem <= nrem;
          quo <= {quo[DW-2:0], qb};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          dbz   <= cond == C_DBZ;
          ovf   <= (cond == C_OVF) || (cond == C_NORM && ovf_fin);
          q     <= (cond != C_NORM || ovf_fin) ? '1 : q_fin;
          r     <= (cond == C_DBZ) ? a_lo : (cond == C_OVF || ovf_fin) ? '0 : r_fin;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider. It is the inverse companion of the team's shift-add multiplier: it takes a double-width dividend and a single-width divisor and produces a single-width quotient and remainder. It computes one quotient bit per clock and uses the same start/busy handshake as the multiplier, so both blocks plug into the datapath ALU controller the same way.

## Interface
Parameters:
- DW, 8: divisor, quotient and remainder width. The dividend is 2*DW wide.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: request. Sampled only in IDLE.
- a, input, 2*DW: dividend.
- b, input, DW: divisor.
- q, output, DW: quotient.
- r, output, DW: remainder.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when q/r/flags are updated.
- dbz, output, 1: divide-by-zero flag for the last result.
- ovf, output, 1: quotient-overflow flag for the last result.

## Operation
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears the iteration counter. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, FIX.
- **IDLE**, start=1: latch a and b into internal registers, set busy=1, clear the counter.
  - If b==0: go to FIX with the dbz condition.
  - Else if the upper half of a (magnitude) is >= b (magnitude): go to FIX with the ovf condition.
  - Else: go to CALC.
- **CALC**: each cycle does one restoring step on the partial remainder.
  - Shift left by 1 and trial-subtract the divisor, with DW+1-bit compare width.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - After exactly DW steps, go to FIX.
- **FIX**: register the results, pulse done, drop busy, and return to IDLE. Register contents per condition:
  - dbz: q = all ones, r = a[DW-1:0], dbz=1, ovf=0.
  - ovf: q = all ones, r = 0, ovf=1, dbz=0.
  - Normal completion: q and r are the computed values; both flags are 0.
- Outputs q, r, dbz and ovf hold their values until the next FIX or reset.
- start while busy=1 is ignored. Changes to a or b while busy have no effect.
- Arithmetic: unsigned by default, with truncating division. The invariant a == q*b + r holds with r < b whenever dbz=0 and ovf=0.

## Timing
- start is sampled at edge E0. busy is high from after E0 through edge E(DW+1).
- Normal case: CALC occupies edges E1..E(DW); FIX is edge E(DW+1). Result latency is DW+1 cycles, so 9 cycles for DW=8.
- dbz and ovf cases skip CALC: FIX is at E1, giving a latency of 1 cycle.
- done is high for exactly the cycle after FIX, the same cycle in which busy first reads 0.
- start may be asserted in the same cycle done is high. It is accepted, so back-to-back operations are possible with no idle gap.

## Configuration
- SEQ_DIVIDER_SIGNED_EN, when defined:
  - a and b are two's complement.
  - The divide runs on magnitudes.
  - FIX negates q if the operand signs differ.
  - r takes the sign of the dividend (truncation toward zero).
  - ovf is additionally set when the signed quotient falls outside [-2^(DW-1), 2^(DW-1)-1].
  - The FIX stage adds no extra cycles.
- Undefined: all values are unsigned and no negation logic is built.

## Structure
- Package seq_divider_pkg holds:
  - the DW default;
  - the FSM state typedef (IDLE/CALC/FIX);
  - the counter width constant $clog2(DW+1).
- One sub-module, div_step: combinational restoring step (partial remainder, divisor) -> (next partial remainder, quotient bit). It is instantiated once and reused each CALC cycle.

## Test plan
- Unsigned 1000/7, start for 1 cycle -> busy for 9 cycles, done pulse; q=142, r=6, flags 0.
- 49/7, start asserted on the done cycle of the previous operation -> accepted immediately; q=7, r=0.
- 100/0 -> done after 1 cycle; dbz=1, q=0xFF, r=0x64. Then 0x0800/4 -> ovf=1, q=0xFF, r=0.
- rst_n low at the 4th CALC cycle -> all outputs 0 immediately, no done pulse. The next start gives a correct result.
- start pulsed again mid-CALC with different operands -> ignored; the result matches the original operands.
- With SEQ_DIVIDER_SIGNED_EN defined:
  - -4096/64 -> q=0xC0 (-64), r=0.
  - -7/2 -> q=0xFD (-3), r=0xFF (-1).
  - -32768/-1 -> ovf=1.
